// File: rtl/d_pipe_reg.sv
// d_pipe_reg: DEPTH-stage registered pipeline with valid/ready flow control,
// bubble collapsing, synchronous flush and an occupancy count.
module d_pipe_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [DEPTH-1:0] rdy;
  logic             rdy_acc;
  logic             in_xfer;
  logic             out_xfer;

  // A stage can load when it is empty or any stage ahead of it can move,
  // which is what lets entries compact into holes behind a stalled output.
  always_comb begin
    rdy     = '0;
    rdy_acc = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy_acc = !v_q[i] || rdy_acc;
      rdy[i]  = rdy_acc;
    end
  end

  always_comb begin
    v_d      = v_q;
    d_d      = d_q;
    in_ready = rdy[0] && !flush;
    in_xfer  = in_valid && in_ready;
    out_xfer = v_q[DEPTH-1] && out_ready;

    if (flush) begin
      v_d = '0;
    end else begin
      if (rdy[0]) begin
        v_d[0] = in_valid;
        if (in_valid) begin
          d_d[0] = in_data;
        end
      end
      // Bubbles move the valid bit only, leaving data registers untouched.
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) begin
            d_d[i] = d_q[i-1];
          end
        end
      end
    end

    count_d = flush ? '0 : (count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q     <= v_d;
      d_q     <= d_d;
      count_q <= count_d;
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;

endmodule
